// File: rtl/mips_reg_write_arbiter.sv
// mips_reg_write_arbiter: two-requester register-file write arbiter.
// Requester A (ALU writeback) and B (load writeback) share one write port.
// Ties go to whichever side holds priority, and priority flips after every
// transfer. The winning write is issued one cycle after its handshake.
// Writes to r0 complete the handshake but are never issued or counted.
// Optional feature: define MIPS_REG_WRITE_FWD_EN to add two forwarding
// compare ports against the write currently being issued.
module mips_reg_write_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [4:0]       a_reg,
   input  logic [31:0]      a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [4:0]       b_reg,
   input  logic [31:0]      b_data,
   output logic             b_ready,
   output logic             signal_reg_write,
   output logic [4:0]       write_reg,
   output logic [31:0]      write_data,
   output logic [CNT_W-1:0] write_count
`ifdef MIPS_REG_WRITE_FWD_EN
   ,
   input  logic [4:0]       fwd_reg_1,
   input  logic [4:0]       fwd_reg_2,
   output logic             fwd_hit_1,
   output logic             fwd_hit_2,
   output logic [31:0]      fwd_data_1,
   output logic [31:0]      fwd_data_2
`endif
);

   typedef enum logic {PRIO_A, PRIO_B} prio_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   prio_t       prio_q, prio_d;
   logic        xfer;
   logic        issue;
   logic [4:0]  win_reg;
   logic [31:0] win_data;

   // Grant decision and next priority; readies are forced low during reset
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      prio_d  = prio_q;
      if (!reset) begin
         if (a_valid && (!b_valid || prio_q == PRIO_A))
            a_ready = 1'b1;
         else if (b_valid)
            b_ready = 1'b1;
      end
      if (a_ready) prio_d = PRIO_B;
      if (b_ready) prio_d = PRIO_A;
   end

   // Winner select; r0 transfers complete the handshake but do not issue
   always_comb begin
      xfer     = a_ready | b_ready;
      win_reg  = a_ready ? a_reg  : b_reg;
      win_data = a_ready ? a_data : b_data;
      issue    = xfer && (win_reg != 5'd0);
   end

   // Priority state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prio_q <= PRIO_A;
      else       prio_q <= prio_d;
   end

   // Issue stage: write port outputs and saturating issued-write counter.
   // The counter moves on the same edge that raises signal_reg_write, so it
   // already includes the write being presented.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         signal_reg_write <= 1'b0;
         write_reg        <= 5'd0;
         write_data       <= 32'd0;
         write_count      <= '0;
      end else begin
         signal_reg_write <= issue;
         if (issue) begin
            write_reg  <= win_reg;
            write_data <= win_data;
            if (write_count != CNT_MAX) write_count <= write_count + 1'b1;
         end
      end
   end

`ifdef MIPS_REG_WRITE_FWD_EN
   // Forwarding compare against the write being issued this cycle
   always_comb begin
      fwd_hit_1  = !reset && signal_reg_write && (write_reg != 5'd0) && (write_reg == fwd_reg_1);
      fwd_hit_2  = !reset && signal_reg_write && (write_reg != 5'd0) && (write_reg == fwd_reg_2);
      fwd_data_1 = fwd_hit_1 ? write_data : 32'd0;
      fwd_data_2 = fwd_hit_2 ? write_data : 32'd0;
   end
`endif

endmodule
